// File: rtl/fifo_packet_reader.sv
// fifo_packet_reader: drains length-prefixed packets from a synchronous FIFO
// (one-cycle read latency), strips the header word and re-emits the payload
// on a valid/ready stream with a last marker through a 2-entry skid buffer.
// Optional status counters are enabled by defining FIFO_PACKET_READER_STATUS_EN.
module fifo_packet_reader #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned LENGTH_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    input  logic                  fifo_read_data_valid,
    output logic                  fifo_read_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready
`ifdef FIFO_PACKET_READER_STATUS_EN
    ,
    output logic [15:0]           packet_count,
    output logic [15:0]           zero_length_count
`endif
);

    localparam int unsigned OCC_W   = 2;
    localparam int unsigned SPACE_W = 3;
`ifdef FIFO_PACKET_READER_STATUS_EN
    localparam int unsigned CNT_W   = 16;
`endif

    typedef enum logic {
        ST_HEADER  = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [LENGTH_WIDTH-1:0] remaining_q, remaining_d;
    logic                    in_flight_q, in_flight_d;
    logic [DATA_WIDTH-1:0]   mem_data_q [2];
    logic [DATA_WIDTH-1:0]   mem_data_d [2];
    logic                    mem_last_q [2];
    logic                    mem_last_d [2];
    logic                    rd_ptr_q, rd_ptr_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
`ifdef FIFO_PACKET_READER_STATUS_EN
    logic [CNT_W-1:0]        pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]        zlc_cnt_q, zlc_cnt_d;
`endif

    logic                    pop;
    logic                    push;
    logic                    push_last;
    logic                    arrival;
    logic                    zero_hdr;
    logic [SPACE_W-1:0]      space_used;
    logic [LENGTH_WIDTH-1:0] hdr_len;

    assign out_valid = (occ_q != '0);
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_last  = out_valid && mem_last_q[rd_ptr_q];
`ifdef FIFO_PACKET_READER_STATUS_EN
    assign packet_count      = pkt_cnt_q;
    assign zero_length_count = zlc_cnt_q;
`endif

    // Read issue: buffer slots still free after this cycle's pop, counting the outstanding read.
    always_comb begin
        pop              = out_valid && out_ready;
        space_used       = SPACE_W'(occ_q) - SPACE_W'(pop) + SPACE_W'(in_flight_q);
        fifo_read_enable = !reset && !fifo_empty && (space_used < SPACE_W'(2));
        arrival          = in_flight_q && fifo_read_data_valid;
        hdr_len          = fifo_read_data[LENGTH_WIDTH-1:0];
    end

    // Header/payload parsing, skid-buffer bookkeeping and status counters.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        in_flight_d = fifo_read_enable;
        mem_data_d  = mem_data_q;
        mem_last_d  = mem_last_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        push        = 1'b0;
        push_last   = 1'b0;
        zero_hdr    = 1'b0;

        if (arrival) begin
            case (state_q)
                ST_HEADER: begin
                    if (hdr_len == '0) begin
                        zero_hdr = 1'b1;
                    end else begin
                        remaining_d = hdr_len;
                        state_d     = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    push        = 1'b1;
                    push_last   = (remaining_q == LENGTH_WIDTH'(1));
                    remaining_d = remaining_q - LENGTH_WIDTH'(1);
                    if (push_last) begin
                        state_d = ST_HEADER;
                    end
                end
                default: state_d = ST_HEADER;
            endcase
        end

        if (push) begin
            mem_data_d[wr_ptr_q] = fifo_read_data;
            mem_last_d[wr_ptr_q] = push_last;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);

`ifdef FIFO_PACKET_READER_STATUS_EN
        pkt_cnt_d = pkt_cnt_q + CNT_W'(pop && out_last);
        zlc_cnt_d = zlc_cnt_q + CNT_W'(zero_hdr);
`endif
    end

    // State registers; reset flushes the buffer and forgets any outstanding read.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_HEADER;
            remaining_q <= '0;
            in_flight_q <= 1'b0;
            mem_data_q  <= '{default: '0};
            mem_last_q  <= '{default: 1'b0};
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            occ_q       <= '0;
`ifdef FIFO_PACKET_READER_STATUS_EN
            pkt_cnt_q   <= '0;
            zlc_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            in_flight_q <= in_flight_d;
            mem_data_q  <= mem_data_d;
            mem_last_q  <= mem_last_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
`ifdef FIFO_PACKET_READER_STATUS_EN
            pkt_cnt_q   <= pkt_cnt_d;
            zlc_cnt_q   <= zlc_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Bench for fifo_packet_reader: a queue-based FIFO model with one-cycle read
// latency feeds the DUT; a packet parser over the popped word stream predicts
// the payload beats, checked every cycle by one monitor, plus directed cases.
module tb_fifo_packet_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_read_data = 16'h0;
    logic        fifo_read_data_valid = 1'b0;
    logic        fifo_read_enable;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b0;
`ifdef FIFO_PACKET_READER_STATUS_EN
    logic [15:0] packet_count;
    logic [15:0] zero_length_count;
`endif

    always #5 clock = ~clock;

    fifo_packet_reader #(.DATA_WIDTH(16), .LENGTH_WIDTH(12)) dut (
        .clock               (clock),
        .reset               (reset),
        .fifo_empty          (fifo_empty),
        .fifo_read_data      (fifo_read_data),
        .fifo_read_data_valid(fifo_read_data_valid),
        .fifo_read_enable    (fifo_read_enable),
        .out_data            (out_data),
        .out_valid           (out_valid),
        .out_last            (out_last),
        .out_ready           (out_ready)
`ifdef FIFO_PACKET_READER_STATUS_EN
        ,
        .packet_count        (packet_count),
        .zero_length_count   (zero_length_count)
`endif
    );

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] fq[$];
    logic [15:0] wq[$];
    logic        pend = 1'b0;
    logic [15:0] pend_w = 16'h0;
    int          m_rem = 0;
    int          m_pkt = 0;
    int          m_zero = 0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          rd_count = 0;
    logic [15:0] hs_d[$];
    logic        hs_l[$];
    int          hs_c[$];
    logic        prev_stall = 1'b0;
    beat_t       prev_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Packet parser: header gives length, following words are payload.
    task automatic parse(input logic [15:0] w);
        beat_t b;
        if (m_rem == 0) begin
            if (w[11:0] == 12'h0) m_zero = (m_zero + 1) % 65536;
            else m_rem = int'(w[11:0]);
        end else begin
            b.d = w;
            b.l = (m_rem == 1);
            exp_q.push_back(b);
            m_rem--;
        end
    endtask

    // FIFO model: read data one cycle after the enable; valid flag held between reads.
    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            fq.delete();
            wq.delete();
            pend = 1'b0;
            m_rem = 0;
            exp_q.delete();
            m_pkt = 0;
            m_zero = 0;
            fifo_empty <= 1'b1;
        end else begin
            if (pend) parse(pend_w);
            pend = 1'b0;
            if (fifo_read_enable && fq.size() > 0) begin
                pend_w = fq.pop_front();
                pend = 1'b1;
                fifo_read_data <= pend_w;
                fifo_read_data_valid <= 1'b1;
            end
            while (wq.size() > 0) fq.push_back(wq.pop_front());
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (fifo_read_enable) rd_count++;
            if (fifo_empty) chk("read_while_empty", 32'(fifo_read_enable), 32'd0);
`ifdef FIFO_PACKET_READER_STATUS_EN
            chk("packet_count", 32'(packet_count), 32'(m_pkt % 65536));
            chk("zero_length_count", 32'(zero_length_count), 32'(m_zero));
`endif
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_b.d));
                chk("hold_last", 32'(out_last), 32'(prev_b.l));
            end
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            if (out_valid && exp_q.size() > 0) begin
                chk("out_data", 32'(out_data), 32'(exp_q[0].d));
                chk("out_last", 32'(out_last), 32'(exp_q[0].l));
                if (out_ready) begin
                    if (exp_q[0].l) m_pkt++;
                    void'(exp_q.pop_front());
                    hs_d.push_back(out_data);
                    hs_l.push_back(out_last);
                    hs_c.push_back(cyc);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_b.d = out_data;
            prev_b.l = out_last;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic clear_logs();
        hs_d.delete();
        hs_l.delete();
        hs_c.delete();
        rd_count = 0;
    endtask

    task automatic do_reset();
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic push(input logic [15:0] w);
        wq.push_back(w);
    endtask

    task automatic wait_hs(input int n, input int budget, input string name);
        int k = 0;
        while (hs_d.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk(name, 32'(hs_d.size() >= n), 32'd1);
        step(1);
    endtask

    initial begin
        int k;
        int len;
        // Reset values.
        step(2);
        @(negedge clock);
        chk("rst_read_enable", 32'(fifo_read_enable), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
`ifdef FIFO_PACKET_READER_STATUS_EN
        chk("rst_packet_count", 32'(packet_count), 32'd0);
        chk("rst_zero_count", 32'(zero_length_count), 32'd0);
`endif
        step(1);
        reset = 1'b0;
        clear_logs();

        // Single 3-word packet, first beat 3 cycles after the first read.
        out_ready = 1'b1;
        push(16'h0003); push(16'hA001); push(16'hA002); push(16'hA003);
        k = 0;
        @(negedge clock);
        while (!fifo_read_enable && k < 10) begin
            @(negedge clock);
            k++;
        end
        chk("t1_first_read", 32'(fifo_read_enable), 32'd1);
        repeat (3) @(negedge clock);
        chk("t1_v0", 32'(out_valid), 32'd1);
        chk("t1_d0", 32'(out_data), 32'hA001);
        chk("t1_l0", 32'(out_last), 32'd0);
        @(negedge clock);
        chk("t1_d1", 32'(out_data), 32'hA002);
        chk("t1_l1", 32'(out_last), 32'd0);
        @(negedge clock);
        chk("t1_d2", 32'(out_data), 32'hA003);
        chk("t1_l2", 32'(out_last), 32'd1);
        @(negedge clock);
        chk("t1_idle", 32'(out_valid), 32'd0);
`ifdef FIFO_PACKET_READER_STATUS_EN
        chk("t1_packet_count", 32'(packet_count), 32'd1);
`endif
        step(1);

        // Zero-length header dropped.
        do_reset();
        out_ready = 1'b1;
        push(16'h0000); push(16'h0001); push(16'hBEEF);
        wait_hs(1, 20, "t2_timeout");
        step(4);
        @(negedge clock);
        chk("t2_beats", 32'(hs_d.size()), 32'd1);
        chk("t2_data", 32'(hs_d[0]), 32'hBEEF);
        chk("t2_last", 32'(hs_l[0]), 32'd1);
`ifdef FIFO_PACKET_READER_STATUS_EN
        chk("t2_zero_count", 32'(zero_length_count), 32'd1);
        chk("t2_packet_count", 32'(packet_count), 32'd1);
`endif
        step(1);

        // Backpressure: 8-word packet with ready low for a while.
        do_reset();
        out_ready = 1'b0;
        push(16'h0008);
        for (int i = 0; i < 8; i++) push(16'h3000 + 16'(i));
        step(12);
        @(negedge clock);
        chk("t3_reads_stalled", 32'(rd_count), 32'd3);
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_first_word", 32'(out_data), 32'h3000);
        step(1);
        out_ready = 1'b1;
        wait_hs(8, 40, "t3_timeout");
        step(2);
        chk("t3_beats", 32'(hs_d.size()), 32'd8);
        chk("t3_reads_total", 32'(rd_count), 32'd9);
        for (int i = 0; i < 8 && i < hs_d.size(); i++) begin
            chk("t3_data", 32'(hs_d[i]), 32'h3000 + 32'(i));
            chk("t3_last", 32'(hs_l[i]), 32'(i == 7));
        end

        // Back-to-back packets: one bubble for the second header.
        do_reset();
        out_ready = 1'b1;
        push(16'h0002); push(16'hC000); push(16'hC001); push(16'h0001); push(16'hD000);
        wait_hs(3, 30, "t4_timeout");
        if (hs_d.size() >= 3) begin
            chk("t4_d0", 32'(hs_d[0]), 32'hC000);
            chk("t4_d1", 32'(hs_d[1]), 32'hC001);
            chk("t4_d2", 32'(hs_d[2]), 32'hD000);
            chk("t4_lasts", {29'h0, hs_l[0], hs_l[1], hs_l[2]}, 32'b011);
            chk("t4_gap01", 32'(hs_c[1] - hs_c[0]), 32'd1);
            chk("t4_gap12", 32'(hs_c[2] - hs_c[1]), 32'd2);
        end

        // Reset mid-packet with a stale read-data-valid flag.
        do_reset();
        out_ready = 1'b0;
        push(16'h0007);
        for (int i = 0; i < 7; i++) push(16'h5000 + 16'(i));
        step(8);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        clear_logs();
        @(negedge clock);
        chk("t5_valid_after_reset", 32'(out_valid), 32'd0);
        chk("t5_no_read", 32'(fifo_read_enable), 32'd0);
`ifdef FIFO_PACKET_READER_STATUS_EN
        chk("t5_packet_count", 32'(packet_count), 32'd0);
        chk("t5_zero_count", 32'(zero_length_count), 32'd0);
`endif
        step(4);
        @(negedge clock);
        chk("t5_stale_ignored", 32'(out_valid), 32'd0);
        step(1);
        out_ready = 1'b1;
        push(16'h0001); push(16'hE000);
        wait_hs(1, 20, "t5_timeout");
        chk("t5_new_data", 32'(hs_d[0]), 32'hE000);
        chk("t5_new_last", 32'(hs_l[0]), 32'd1);

        // FIFO runs dry mid-payload, then resumes.
        do_reset();
        out_ready = 1'b1;
        push(16'h0006);
        for (int i = 0; i < 4; i++) push(16'hF000 + 16'(i));
        step(12);
        @(negedge clock);
        chk("t6_dry_valid", 32'(out_valid), 32'd0);
        chk("t6_dry_beats", 32'(hs_d.size()), 32'd4);
        chk("t6_dry_last", 32'(hs_l[3]), 32'd0);
        step(1);
        push(16'hF004); push(16'hF005);
        wait_hs(6, 20, "t6_timeout");
        chk("t6_d4", 32'(hs_d[4]), 32'hF004);
        chk("t6_l4", 32'(hs_l[4]), 32'd0);
        chk("t6_d5", 32'(hs_d[5]), 32'hF005);
        chk("t6_l5", 32'(hs_l[5]), 32'd1);

        // Randomized traffic and backpressure against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 5) == 0) begin
                len = int'($urandom_range(0, 6));
                push({4'($urandom_range(0, 15)), 12'(len)});
                for (int i = 0; i < len; i++) push(16'($urandom));
            end
            step(1);
        end
        out_ready = 1'b1;
        k = 0;
        while ((exp_q.size() > 0 || fq.size() > 0 || wq.size() > 0 || pend || out_valid) && k < 2000) begin
            step(1);
            k++;
        end
        chk("random_drained", 32'(exp_q.size() + fq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
